// File: rtl/cordic_sched.sv
// Purpose: round-robin scheduler and strobe sequencer for one shared CORDIC rotation datapath.
// Latency: grant to resp_valid is E+3 cycles (18 at BIT_WIDTH=16), with one job in flight.
// Backpressure: no grant while the one-entry result buffer is full and resp_ready is low.
// Build option: define CORDIC_SCHED_ABORT_EN to add the abort input and aborted pulse output.
module cordic_sched #(
   parameter int BIT_WIDTH       = 16,
   parameter int LOG_2_BIT_WIDTH = 4,
   parameter int NUM_REQ         = 4,
   parameter int ID_W            = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*BIT_WIDTH-1:0] req_target,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [ID_W-1:0]              resp_id,
   output logic [BIT_WIDTH-1:0]         resp_x,
   output logic [BIT_WIDTH-1:0]         resp_y,
   output logic                         busy,
`ifdef CORDIC_SCHED_ABORT_EN
   input  logic                         abort,
   output logic                         aborted,
`endif
   output logic                         dp_load_regs,
   output logic                         dp_add,
   output logic                         dp_sub,
   output logic                         dp_iter,
   output logic [BIT_WIDTH-1:0]         dp_target,
   input  logic                         dp_reached_target,
   input  logic                         dp_dir,
   input  logic [BIT_WIDTH-1:0]         dp_x,
   input  logic [BIT_WIDTH-1:0]         dp_y
);

   // The iteration index width must cover the datapath run and the ID must cover all requesters.
   if (NUM_REQ < 2 || NUM_REQ > 16 || (1 << ID_W) < NUM_REQ ||
       (1 << LOG_2_BIT_WIDTH) < BIT_WIDTH) begin : g_bad_cfg
      $error("cordic_sched: inconsistent parameter set");
   end

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP} state_t;

   state_t                 state_q, state_d;
   logic [ID_W-1:0]        last_grant_q;
   logic [ID_W-1:0]        cur_id_q;
   logic [BIT_WIDTH-1:0]   dp_target_q;
   logic                   resp_valid_q;
   logic [ID_W-1:0]        resp_id_q;
   logic [BIT_WIDTH-1:0]   resp_x_q, resp_y_q;

   logic                   slot_free;
   logic                   grant;
   logic                   capture;
   logic                   abort_req;
   logic                   hi_found, lo_found;
   logic [ID_W-1:0]        hi_idx, lo_idx, gnt_idx;
   logic [BIT_WIDTH-1:0]   gnt_target;

   assign slot_free = !resp_valid_q | resp_ready;
   assign grant     = reset_n & (state_q == S_IDLE) & slot_free & (|req_valid);

`ifdef CORDIC_SCHED_ABORT_EN
   logic aborted_q, aborted_d;

   assign abort_req = abort;
   // A capture in the same cycle beats an abort, so reaching the target masks it.
   assign aborted_d = abort & ((state_q == S_LOAD) | ((state_q == S_STEP) & !dp_reached_target));

   // One-cycle pulse on the edge where a run is abandoned.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) aborted_q <= 1'b0;
      else          aborted_q <= aborted_d;
   end

   assign aborted = aborted_q;
`else
   assign abort_req = 1'b0;
`endif

   // Round-robin pick: first valid above last_grant, else first valid from index 0.
   always_comb begin
      hi_found   = 1'b0;
      lo_found   = 1'b0;
      hi_idx     = '0;
      lo_idx     = '0;
      gnt_target = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!hi_found && req_valid[j] && (ID_W'(j) > last_grant_q)) begin
            hi_found = 1'b1;
            hi_idx   = ID_W'(j);
         end
         if (!lo_found && req_valid[j]) begin
            lo_found = 1'b1;
            lo_idx   = ID_W'(j);
         end
      end
      gnt_idx = hi_found ? hi_idx : lo_idx;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (gnt_idx == ID_W'(j)) gnt_target = req_target[j*BIT_WIDTH +: BIT_WIDTH];
      end
   end

   // One-hot ready toward the winner only, and only while a grant is actually taken.
   always_comb begin
      req_ready = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         req_ready[j] = grant & (gnt_idx == ID_W'(j));
      end
   end

   // Next-state and datapath strobes; add/sub/iter only while the target is not reached.
   always_comb begin
      state_d      = state_q;
      dp_load_regs = 1'b0;
      dp_add       = 1'b0;
      dp_sub       = 1'b0;
      dp_iter      = 1'b0;
      capture      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (grant) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (abort_req) begin
               state_d = S_IDLE;
            end else begin
               dp_load_regs = 1'b1;
               state_d      = S_STEP;
            end
         end
         S_STEP: begin
            if (dp_reached_target) begin
               capture = 1'b1;
               state_d = S_IDLE;
            end else if (abort_req) begin
               state_d = S_IDLE;
            end else begin
               dp_iter = 1'b1;
               dp_add  = dp_dir;
               dp_sub  = !dp_dir;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, arbitration pointer and the target/ID latched at grant time.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         cur_id_q     <= '0;
         dp_target_q  <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            last_grant_q <= gnt_idx;
            cur_id_q     <= gnt_idx;
            dp_target_q  <= gnt_target;
         end
      end
   end

   // Result buffer: a capture wins over a drain in the same cycle; data holds while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_x_q     <= '0;
         resp_y_q     <= '0;
      end else if (capture) begin
         resp_valid_q <= 1'b1;
         resp_id_q    <= cur_id_q;
         resp_x_q     <= dp_x;
         resp_y_q     <= dp_y;
      end else if (resp_ready) begin
         resp_valid_q <= 1'b0;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign dp_target  = dp_target_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_x     = resp_x_q;
   assign resp_y     = resp_y_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: behavioural binary-search datapath, scoreboard of expected results.
// The datapath model reports x = accumulated angle, y = {add count, sub count} after 15 steps.
// Expected results per target are hand-worked from that model and pushed when a grant occurs.
module tb_cordic_sched;
   localparam int BW = 16;
   localparam int NR = 4;
   localparam int IW = 2;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [BW-1:0] x;
      logic [BW-1:0] y;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n;
   logic [NR-1:0]     req_valid;
   logic [NR*BW-1:0]  req_target;
   logic [NR-1:0]     req_ready;
   logic              resp_valid, resp_ready;
   logic [IW-1:0]     resp_id;
   logic [BW-1:0]     resp_x, resp_y;
   logic              busy;
   logic              dp_load_regs, dp_add, dp_sub, dp_iter;
   logic [BW-1:0]     dp_target;
   logic              dp_reached_target, dp_dir;
   logic [BW-1:0]     dp_x, dp_y;
`ifdef CORDIC_SCHED_ABORT_EN
   logic              abort, aborted;
`endif

   cordic_sched dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_target(req_target), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_x(resp_x), .resp_y(resp_y), .busy(busy),
`ifdef CORDIC_SCHED_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .dp_load_regs(dp_load_regs), .dp_add(dp_add), .dp_sub(dp_sub), .dp_iter(dp_iter),
      .dp_target(dp_target), .dp_reached_target(dp_reached_target), .dp_dir(dp_dir),
      .dp_x(dp_x), .dp_y(dp_y)
   );

   // Datapath model: z walks toward the target in halving steps; 15 steps per run.
   logic [BW-1:0] m_z = '0;
   logic [4:0]    m_i = '0;
   logic [7:0]    m_adds = '0, m_subs = '0;
   always @(posedge clk) begin
      if (dp_load_regs) begin
         m_z <= '0; m_i <= '0; m_adds <= '0; m_subs <= '0;
      end else if (dp_iter) begin
         if (dp_add) begin m_z <= m_z + (16'h4000 >> m_i); m_adds <= m_adds + 8'd1; end
         else if (dp_sub) begin m_z <= m_z - (16'h4000 >> m_i); m_subs <= m_subs + 8'd1; end
         m_i <= m_i + 5'd1;
      end
   end
   assign dp_reached_target = (m_i == 5'd15);
   assign dp_dir            = ($signed(m_z) < $signed(dp_target));
   assign dp_x              = m_z;
   assign dp_y              = {m_adds, m_subs};

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   exp_t exp_q[$];
   int   grant_ids[$];
   int   grant_cyc[$];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Hand-worked {x, y} for each target the bench uses.
   function automatic logic [31:0] exp_xy(input logic [BW-1:0] t);
      case (t)
         16'h2000: return {16'h1FFF, 16'h0D02};
         16'h4000: return {16'h3FFF, 16'h0E01};
         16'h1000: return {16'h0FFF, 16'h0C03};
         16'h0000: return {16'hFFFF, 16'h0E01};
         16'h3000: return {16'h2FFF, 16'h0D02};
         16'h0800: return {16'h07FF, 16'h0B04};
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Grant logger: a transfer pushes the expected response for that requester's target.
   always @(negedge clk) begin
      if (reset_n) begin
         for (int k = 0; k < NR; k++) begin
            if (req_valid[k] && req_ready[k]) begin
               exp_q.push_back({IW'(k), exp_xy(req_target[k*BW +: BW])});
               grant_ids.push_back(k);
               grant_cyc.push_back(cyc);
            end
         end
      end
   end

   // Response monitor and protocol invariants.
   always @(negedge clk) begin
      exp_t e;
      check("protocol", {29'd0, dp_add & dp_sub, !$onehot0(req_ready),
                         dp_load_regs & (dp_add | dp_sub | dp_iter)}, 32'd0);
      if (resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_resp: got id %0d x 0x%0h, expected no response", resp_id, resp_x);
         end else begin
            e = exp_q.pop_front();
            check("resp_id", 32'(resp_id), 32'(e.id));
            check("resp_x",  32'(resp_x),  32'(e.x));
            check("resp_y",  32'(resp_y),  32'(e.y));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while ((busy || resp_valid || exp_q.size() != 0) && n < budget) begin tick(); n++; end
      check(name, {31'd0, (busy || resp_valid || exp_q.size() != 0)}, 32'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0; tick(); tick();
      reset_n = 1'b1; tick();
      exp_q.delete(); grant_ids.delete(); grant_cyc.delete();
   endtask

   logic [BW-1:0] tgt_tab[6] = '{16'h2000, 16'h4000, 16'h1000, 16'h0000, 16'h3000, 16'h0800};
   int            exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      int n_ok;
      logic [NR-1:0] granted_prev;
      reset_n = 1'b0; req_valid = 4'hF; req_target = '0; resp_ready = 1'b0;
`ifdef CORDIC_SCHED_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      // Reset values; req_valid is high to show req_ready is forced low.
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
      check("rst_resp_xy", {resp_x, resp_y}, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_strobes", {28'd0, dp_load_regs, dp_add, dp_sub, dp_iter}, 32'd0);
      check("rst_dp_target", 32'(dp_target), 32'd0);
      req_valid = '0;
      tick(); reset_n = 1'b1; tick();

      // Single job from requester 2.
      resp_ready = 1'b1;
      req_target[2*BW +: BW] = 16'h2000; req_valid = 4'b0100; #1;
      check("t1_grant", 32'(req_ready), 32'b0100);
      tick(); req_valid = '0;
      check("t1_load", {29'd0, dp_load_regs, dp_add | dp_sub, dp_iter}, 32'b100);
      n_ok = 0;
      repeat (15) begin
         tick();
         if (dp_iter && (dp_add ^ dp_sub) && !dp_load_regs) n_ok++;
      end
      check("t1_step_strobes", 32'(n_ok), 32'd15);
      tick();
      check("t1_c17_strobes", {28'd0, dp_load_regs, dp_add, dp_sub, dp_iter}, 32'd0);
      check("t1_c17_resp_valid", 32'(resp_valid), 32'd0);
      tick();
      check("t1_c18_resp_valid", 32'(resp_valid), 32'd1);
      check("t1_c18_resp_id", 32'(resp_id), 32'd2);
      drain(30, "t1_drain");

      // All four requesters from reset: order 0,1,2,3,0 at 18-cycle spacing.
      do_reset();
      req_target = {16'h0000, 16'h0800, 16'h1000, 16'h4000};
      req_valid  = 4'hF;
      for (int n = 0; n < 120 && grant_ids.size() < 5; n++) tick();
      req_valid = '0;
      check("t2_grant_count", 32'(grant_ids.size()), 32'd5);
      for (int i = 0; i < 5 && i < grant_ids.size(); i++) begin
         check("t2_grant_order", 32'(grant_ids[i]), 32'(exp_order[i]));
         if (i > 0) check("t2_grant_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd18);
      end
      drain(40, "t2_drain");

      // Backpressure: result stalls, no grant, then grant in the cycle resp_ready rises.
      resp_ready = 1'b0;
      req_target[1*BW +: BW] = 16'h1000; req_target[3*BW +: BW] = 16'h3000;
      req_valid = 4'b1010; #1;
      check("t3_grant", 32'(req_ready), 32'b0010);
      tick(); req_valid = 4'b1000;
      repeat (17) tick();
      check("t3_resp_valid", 32'(resp_valid), 32'd1);
      repeat (4) begin
         tick();
         check("t3_stall_ready", 32'(req_ready), 32'd0);
         check("t3_stall_valid", 32'(resp_valid), 32'd1);
         check("t3_stall_data", {resp_x, resp_y}, {16'h0FFF, 16'h0C03});
         check("t3_stall_id", 32'(resp_id), 32'd1);
      end
      resp_ready = 1'b1; #1;
      check("t3_release_grant", 32'(req_ready), 32'b1000);
      tick(); req_valid = '0;
      drain(40, "t3_drain");

      // Reset in the middle of a run.
      req_target[0 +: BW] = 16'h2000; req_valid = 4'b0001; #1;
      check("t4_grant", 32'(req_ready), 32'b0001);
      tick(); req_valid = '0;
      repeat (7) tick();
      req_valid = 4'b0100; reset_n = 1'b0; #1;
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_strobes", {28'd0, dp_load_regs, dp_add, dp_sub, dp_iter}, 32'd0);
      check("t4_dp_target", 32'(dp_target), 32'd0);
      check("t4_resp", {31'd0, resp_valid}, 32'd0);
      check("t4_resp_xy", {resp_x, resp_y}, 32'd0);
      check("t4_req_ready", 32'(req_ready), 32'd0);
      exp_q.delete();
      tick(); req_valid = '0; reset_n = 1'b1; tick();
      req_target[2*BW +: BW] = 16'h4000; req_valid = 4'b0100; #1;
      check("t4_post_grant", 32'(req_ready), 32'b0100);
      tick(); req_valid = '0;
      drain(40, "t4_drain");

`ifdef CORDIC_SCHED_ABORT_EN
      // Abort at cycle 5; requester 3 is granted at cycle 6.
      req_target[1*BW +: BW] = 16'h2000; req_valid = 4'b0010; #1;
      check("t5_grant", 32'(req_ready), 32'b0010);
      tick(); req_target[3*BW +: BW] = 16'h0800; req_valid = 4'b1000;
      repeat (4) tick();
      abort = 1'b1; #1;
      check("t5_abort_strobes", {28'd0, dp_load_regs, dp_add, dp_sub, dp_iter}, 32'd0);
      exp_q.delete();
      tick(); abort = 1'b0;
      check("t5_aborted", 32'(aborted), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_resp_valid", 32'(resp_valid), 32'd0);
      check("t5_next_grant", 32'(req_ready), 32'b1000);
      tick(); req_valid = '0;
      check("t5_aborted_pulse", 32'(aborted), 32'd0);
      drain(40, "t5_drain");
`endif

      // Random traffic; requesters hold until granted.
      granted_prev = '0;
      repeat (400) begin
         tick();
         for (int k = 0; k < NR; k++) begin
            if (granted_prev[k]) req_valid[k] = 1'b0;
            else if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
               req_valid[k] = 1'b1;
               req_target[k*BW +: BW] = tgt_tab[$urandom_range(0, 5)];
            end
         end
         resp_ready = ($urandom_range(0, 2) != 0);
         #1;
         granted_prev = req_valid & req_ready;
      end
      tick(); req_valid = '0; resp_ready = 1'b1;
      drain(60, "rand_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cordic_sched.md
# cordic_sched

Round-robin scheduler and sequencer for a single shared CORDIC rotation datapath. It accepts angle requests from `NUM_REQ` independent requesters over valid/ready handshakes and grants one at a time. It drives the datapath's `load_regs`, `add`, `sub` and `iter` strobes for a full iteration run, then returns the captured magnitude pair (`x`, `y`) with the requester ID through a one-entry result buffer. It sits between the request fabric and the CORDIC datapath.

## Interface
- `BIT_WIDTH`, 16: width of target and of `x`/`y` results.
- `LOG_2_BIT_WIDTH`, 4: width of the datapath iteration index; matches the datapath instance.
- `NUM_REQ`, 4: number of requesters, range 2..16.
- `ID_W`, 2: width of `resp_id`, equal to ceil(log2(`NUM_REQ`)).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request.
- `req_target` in `NUM_REQ*BIT_WIDTH`: per-requester angle; slice k is `[k*BIT_WIDTH +: BIT_WIDTH]`.
- `req_ready` out `NUM_REQ`: one-hot grant; a transfer occurs when `req_valid[k] & req_ready[k]`.
- `resp_valid` out 1: result buffer full.
- `resp_ready` in 1: consumer accepts the result.
- `resp_id` out `ID_W`: index of the requester that owns the result.
- `resp_x`, `resp_y` out `BIT_WIDTH`: captured magnitudes.
- `busy` out 1: a datapath run is in progress (state ≠ IDLE).
- `dp_load_regs`, `dp_add`, `dp_sub`, `dp_iter` out 1: datapath strobes.
- `dp_target` out `BIT_WIDTH`: registered target driven to the datapath.
- `dp_reached_target`, `dp_dir` in 1: datapath status.
- `dp_x`, `dp_y` in `BIT_WIDTH`: datapath magnitude outputs.

## Operation
- **States:** IDLE, LOAD, STEP.
- **IDLE:**
  - A slot is free when `!resp_valid | resp_ready`.
  - If a slot is free and any `req_valid` is high, grant the first asserted requester searching from `last_grant+1` modulo `NUM_REQ`.
  - `req_ready` is high for the granted requester only, in that same cycle.
  - On the grant, latch the requester's target into `dp_target` and its index into `cur_id`, set `last_grant`, and go to LOAD.
  - `req_ready` is all-zero in every other state and whenever no slot is free.
- **LOAD:** `dp_load_regs=1` for exactly one cycle, then go to STEP.
- **STEP:**
  - While `!dp_reached_target`: `dp_iter=1`. Also assert `dp_add` if `dp_dir`, otherwise `dp_sub`.
  - `dp_add` and `dp_sub` are never high together. Neither is ever high together with `dp_load_regs`.
  - When `dp_reached_target`: assert no strobes, capture `dp_x`, `dp_y` and `cur_id` into the result buffer, set `resp_valid`, and go to IDLE.
- **Result buffer:**
  - `resp_valid` clears on `resp_valid & resp_ready` unless a new capture happens in the same cycle; a capture wins.
  - `resp_x`, `resp_y` and `resp_id` hold stable while `resp_valid & !resp_ready`.
- **Requesters:** a requester must hold `req_valid` and `req_target` until granted. The block does not latch requests that are not granted.
- **Reset:**
  - Asynchronous, to IDLE.
  - `last_grant = NUM_REQ-1`, so requester 0 has the highest priority on the first arbitration.
  - Every output reads 0: `resp_valid`, `resp_id`, `resp_x`, `resp_y`, `busy`, all `dp_*` strobes, `dp_target`. `req_ready` is forced to 0 while `reset_n` is low.
  - Reset asserted mid-run abandons the job with no response. The datapath is reloaded by the next LOAD.

## Timing
- Accept at cycle 0 (IDLE). `dp_load_regs` is high at cycle 1. STEP strobes are high at cycles 2..E+1, where E = datapath end index; for `BIT_WIDTH`=16, E=15. `dp_reached_target` is seen at cycle E+2. `resp_valid` is high from cycle E+3.
- Accept-to-result latency is E+3 cycles (18 for E=15).
- Back-to-back throughput is one job per E+3 cycles. The next grant can occur at cycle E+3 if the slot is free: either the buffer was drained, or `resp_ready` is high in that cycle.
- If `resp_valid` is high and `resp_ready` is low in IDLE, no grant occurs. The block stalls in IDLE without limit.
- Arbitration is fair: a requester that holds `req_valid` is granted within `NUM_REQ` grants.

## Configuration
- `CORDIC_SCHED_ABORT_EN` defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - `abort` high in LOAD or STEP returns the FSM to IDLE on the next edge, with no strobes that cycle and no result capture.
  - `aborted` pulses for one cycle on that edge.
  - `abort` in IDLE is ignored. `abort` in the same cycle as a capture loses; the result is captured.
- `CORDIC_SCHED_ABORT_EN` undefined: neither port exists, and runs always complete.

## Test plan
- Reset, then requester 2 sends target 0x2000 with `resp_ready`=1 → `req_ready`=0b0100 at cycle 0. `dp_load_regs` is high at cycle 1. 15 cycles have exactly one of `dp_add`/`dp_sub` high, each with `dp_iter`. `resp_valid` is high at cycle 18 with `resp_id`=2 and `resp_x`/`resp_y` equal to a reference model.
- All four requesters hold `req_valid` from reset with `resp_ready`=1 → grant order 0,1,2,3,0. Grants are 18 cycles apart.
- `resp_ready`=0 after the first result → no `req_ready` while `resp_valid` is high. `resp_x`/`resp_y`/`resp_id` stay stable. Raising `resp_ready` produces a grant in the same cycle.
- `reset_n` pulled low at cycle 8 of a run → all outputs 0 asynchronously. After release, a new request completes normally and the old job produces no response.
- Assertions over random traffic: `dp_add & dp_sub` is never high; `req_ready` is one-hot or zero; `dp_load_regs` is never high together with `dp_add`, `dp_sub` or `dp_iter`.
- With `CORDIC_SCHED_ABORT_EN`: `abort` at cycle 5 → one-cycle `aborted` pulse, no `resp_valid`, and a grant to the next requester at cycle 6.
